fsm_sw_led: RTL and testbench

- Five-state Moore controller that steers a 3-bit LED output from a 3-bit slide-switch input.
- Switch inputs are asynchronous board signals. They pass through a synchronizer before the state logic.
- The block sits between the board switch pins and the LED driver pins in a top-level board wrapper.

---
 rtl/fsm_sw_led_pkg.sv | 39 +++
 rtl/fsm_sw_led_bus_sync.sv | 39 +++
 rtl/fsm_sw_led.sv | 76 +++++++
 tb/tb_fsm_sw_led.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_sw_led_pkg.sv
// Shared definitions for the switch-to-LED controller.
//   state_t     : binary-encoded controller states (3 bits, 5 used)
//   LED_*       : LED pattern driven in each state
//   SW_*        : switch codes recognised by the transition logic
//   led_decode  : state -> LED pattern (unused encodings map to LED_IDLE)
package fsm_sw_led_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ST1  = 3'd1,
    ST2  = 3'd2,
    ST3  = 3'd3,
    ST4  = 3'd4
  } state_t;

  localparam logic [2:0] LED_IDLE = 3'b000;
  localparam logic [2:0] LED_ST1  = 3'b001;
  localparam logic [2:0] LED_ST2  = 3'b010;
  localparam logic [2:0] LED_ST3  = 3'b100;
  localparam logic [2:0] LED_ST4  = 3'b111;

  localparam logic [2:0] SW_NONE = 3'b000;
  localparam logic [2:0] SW_1    = 3'b001;
  localparam logic [2:0] SW_2    = 3'b010;
  localparam logic [2:0] SW_3    = 3'b100;
  localparam logic [2:0] SW_ALL  = 3'b111;

  function automatic logic [2:0] led_decode(input state_t st);
    case (st)
      IDLE:    return LED_IDLE;
      ST1:     return LED_ST1;
      ST2:     return LED_ST2;
      ST3:     return LED_ST3;
      ST4:     return LED_ST4;
      default: return LED_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fsm_sw_led_bus_sync.sv
// Multi-bit flip-flop synchronizer chain for quasi-static board inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d     : asynchronous input bus
//   q     : synchronized bus (equals d when STAGES == 0)
// Only suitable for slowly changing signals such as switches, where a
// one-cycle skew between bits of the bus is harmless.
module bus_sync #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_sync
      logic [WIDTH-1:0] stage_q [STAGES];

      // NOTE: the synchronizer flops are reset so that a released block
      // starts from a known 000 sample rather than stale pin history.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d;
          for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q = stage_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/fsm_sw_led.sv
// Five-state Moore controller steering a 3-bit LED output from slide
// switches.
//   clk   : system clock, all state changes on the rising edge
//   reset : asynchronous active-low reset (state IDLE, led 000, sync 000)
//   sw    : switch code, asynchronous to clk
//   led   : registered LED pattern of the current state
// SYNC_STAGES (0..3) sets the depth of the sw synchronizer; 0 bypasses it.
module fsm_sw_led
  import fsm_sw_led_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw,
  output logic [2:0] led
);

  state_t     state;
  state_t     next_state;
  logic [2:0] s;

  bus_sync #(
    .WIDTH  (3),
    .STAGES (SYNC_STAGES)
  ) u_sw_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (sw),
    .q     (s)
  );

  // Equality tests against X/Z evaluate false, so unknown switch values
  // fall through to the hold default.
  always_comb begin
    // NOTE: next_state gets a default before the case so every path
    // assigns it and no latch is inferred.
    next_state = state;
    case (state)
      IDLE: begin
        if (s == SW_1)      next_state = ST1;
        else if (s == SW_2) next_state = ST2;
      end
      ST1: begin
        if (s == SW_2)      next_state = ST2;
        else if (s == SW_3) next_state = ST3;
      end
      ST2: begin
        if (s == SW_3)      next_state = ST3;
      end
      ST3: begin
        if (s == SW_ALL)       next_state = ST4;
        else if (s == SW_NONE) next_state = IDLE;
      end
      ST4: begin
        if (s == SW_3)      next_state = ST3;
      end
      default: next_state = IDLE;  // recover from unused encodings
    endcase
  end

  // led is loaded from the decode of next_state so it changes on the same
  // edge as state, with no combinational path from sw to the pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      led   <= LED_IDLE;
    end else begin
      // NOTE: non-blocking assignments keep state and led sampled from the
      // same pre-edge values, independent of statement order.
      state <= next_state;
      led   <= led_decode(next_state);
    end
  end

endmodule

// File: tb/tb_fsm_sw_led.sv
// Self-checking bench for fsm_sw_led. Two instances run side by side on
// the same switches: one with the default two-stage synchronizer, one with
// SYNC_STAGES = 0. A vector table drives switch codes; expected LED values
// are queued per cycle when each code is driven and popped after each edge.
module tb_fsm_sw_led;
  import fsm_sw_led_pkg::*;

  localparam int SA   = 2;   // synchronizer depth of dut_a
  localparam int S0   = 0;   // synchronizer depth of dut_0
  localparam int HOLD = 10;  // cycles each table entry is held

  typedef struct {
    logic [2:0] sw;
    logic [2:0] led;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [2:0] sw;
  logic [2:0] led_a;
  logic [2:0] led_0;

  int n_cmp;
  int n_bad;

  logic [2:0] exp_q_a [$];
  logic [2:0] exp_q_0 [$];
  logic [2:0] prev_a;
  logic [2:0] prev_0;
  vec_t       vecs [$];

  fsm_sw_led #(.SYNC_STAGES(SA)) dut_a (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .led   (led_a)
  );

  fsm_sw_led #(.SYNC_STAGES(S0)) dut_0 (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .led   (led_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [2:0] act,
                       input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, want %b", name, $time, act, exp);
    end
  endtask

  // Drive one switch code, queue the per-cycle expectations for both
  // instances, then compare after each of the following HOLD edges.
  task automatic run_vec(input logic [2:0] sw_v, input logic [2:0] led_v);
    logic [2:0] ea;
    logic [2:0] e0;
    @(negedge clk);
    sw = sw_v;
    for (int j = 0; j < HOLD; j++) begin
      exp_q_a.push_back((j >= SA) ? led_v : prev_a);
      exp_q_0.push_back((j >= S0) ? led_v : prev_0);
    end
    for (int j = 0; j < HOLD; j++) begin
      @(posedge clk);
      #1;
      if (exp_q_a.size() == 0 || exp_q_0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: expectation queue empty at %0t", $time);
      end else begin
        ea = exp_q_a.pop_front();
        e0 = exp_q_0.pop_front();
        check($sformatf("led_s2 sw=%b cyc%0d", sw_v, j), led_a, ea);
        check($sformatf("led_s0 sw=%b cyc%0d", sw_v, j), led_0, e0);
      end
    end
    prev_a = led_v;
    prev_0 = led_v;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    prev_a = 3'b000;
    prev_0 = 3'b000;

    // Forward path, detour IDLE->ST1->ST3->IDLE->ST2, holds, ST4 hold.
    vecs.push_back(vec_t'{3'b000, 3'b000});
    vecs.push_back(vec_t'{3'b001, 3'b001});
    vecs.push_back(vec_t'{3'b010, 3'b010});
    vecs.push_back(vec_t'{3'b100, 3'b100});
    vecs.push_back(vec_t'{3'b111, 3'b111});
    vecs.push_back(vec_t'{3'b100, 3'b100});
    vecs.push_back(vec_t'{3'b000, 3'b000});
    vecs.push_back(vec_t'{3'b001, 3'b001});
    vecs.push_back(vec_t'{3'b100, 3'b100});
    vecs.push_back(vec_t'{3'b000, 3'b000});
    vecs.push_back(vec_t'{3'b010, 3'b010});
    vecs.push_back(vec_t'{3'b001, 3'b010});  // ST2 holds on 001
    vecs.push_back(vec_t'{3'b111, 3'b010});  // ST2 holds on 111
    vecs.push_back(vec_t'{3'b100, 3'b100});
    vecs.push_back(vec_t'{3'b111, 3'b111});
    vecs.push_back(vec_t'{3'b000, 3'b111});  // ST4 holds on 000
    vecs.push_back(vec_t'{3'b100, 3'b100});
    vecs.push_back(vec_t'{3'b000, 3'b000});
    vecs.push_back(vec_t'{3'b100, 3'b000});  // IDLE holds on 100

    // Reset held with all switches on.
    reset = 1'b0;
    sw    = 3'b111;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("reset_led_s2", led_a, 3'b000);
      check("reset_led_s0", led_0, 3'b000);
    end
    check("reset_state", dut_a.state, 3'(IDLE));

    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i].sw, vecs[i].led);

    // Mid-cycle switch activity: led may only move on rising edges.
    #1 sw = 3'b001;
    #1 sw = 3'b010;
    #1 sw = 3'b001;
    #4;
    check("glitch_between_edges_s2", led_a, 3'b000);
    check("glitch_between_edges_s0", led_0, 3'b000);
    @(posedge clk);
    #1;
    check("latency_edge0_s0", led_0, 3'b001);
    check("latency_edge0_s2", led_a, 3'b000);
    @(posedge clk);
    #1;
    check("latency_edge1_s2", led_a, 3'b000);
    @(posedge clk);
    #1;
    check("latency_edge2_s2", led_a, 3'b001);
    prev_a = 3'b001;
    prev_0 = 3'b001;

    run_vec(3'b010, 3'b010);

    // Unused state encoding recovers to IDLE on the next edge.
    #1 force dut_a.state = state_t'(3'b110);
    #1 release dut_a.state;
    @(posedge clk);
    #1;
    check("illegal_led", led_a, 3'b000);
    check("illegal_state", dut_a.state, 3'(IDLE));
    check("illegal_other_inst", led_0, 3'b010);
    @(posedge clk);
    #1;
    check("illegal_recover", led_a, 3'b010);

    // Reach ST4, then assert reset between edges.
    run_vec(3'b100, 3'b100);
    run_vec(3'b111, 3'b111);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_s2", led_a, 3'b000);
    check("async_reset_s0", led_0, 3'b000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold_s2", led_a, 3'b000);
      check("reset_hold_s0", led_0, 3'b000);
    end
    @(negedge clk);
    reset  = 1'b1;
    prev_a = 3'b000;
    prev_0 = 3'b000;
    run_vec(3'b111, 3'b000);  // IDLE ignores 111 after release
    run_vec(3'b001, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
